booth_result_reader: RTL and testbench

- Reader at the far end of the shared 8-bit result bus in the Booth multiplier.
- The A and Q registers drive the bus tri-state, each only while its output-enable is high.
- This block sequences those enables with a turnaround gap between them and captures A (high byte) then Q (low byte).
- It presents the 16-bit product to the downstream consumer on a valid/ready handshake.

---
 rtl/booth_result_reader.sv | 79 +++++++
 tb/tb_booth_result_reader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_result_reader.sv
// rtl/booth_result_reader.sv - sequences A/Q bus enables, captures {A,Q} and hands the product off on valid/ready
module booth_result_reader #(
    parameter int W    = 8,
    parameter int TURN = 1
) (
    input  logic           clk,
    input  logic           rst_b,
    input  logic           start,
    input  logic [W-1:0]   ibus,
    output logic           ld_obus_a,
    output logic           ld_obus_q,
    output logic           busy,
    output logic [2*W-1:0] prod,
    output logic           prod_valid,
    input  logic           out_ready,
    output logic           rd_done
);

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        RD_A  = 5'b00010,
        GAP   = 5'b00100,
        RD_Q  = 5'b01000,
        VALID = 5'b10000
    } state_t;

    localparam logic [1:0] TURN_LD = (TURN > 0) ? 2'(TURN - 1) : 2'd0;

    state_t     state;
    logic [1:0] turn_cnt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= IDLE;
            turn_cnt <= 2'd0;
            prod     <= '0;
            rd_done  <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) state <= RD_A;
                end
                RD_A: begin
                    prod[2*W-1:W] <= ibus;
                    if (TURN == 0) begin
                        state <= RD_Q;
                    end else begin
                        state    <= GAP;
                        turn_cnt <= TURN_LD;
                    end
                end
                GAP: begin
                    // counter loaded with TURN-1, so GAP lasts exactly TURN cycles
                    if (turn_cnt == 2'd0) state <= RD_Q;
                    else                  turn_cnt <= turn_cnt - 2'd1;
                end
                RD_Q: begin
                    prod[W-1:0] <= ibus;
                    state       <= VALID;
                end
                VALID: begin
                    if (out_ready) begin
                        rd_done <= 1'b1;
                        state   <= start ? RD_A : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // enables are raw one-hot state flops so they cannot glitch
    assign ld_obus_a  = state[1];
    assign ld_obus_q  = state[3];
    assign prod_valid = state[4];
    assign busy       = ~state[0];

endmodule

// File: tb/tb_booth_result_reader.sv
// tb/tb_booth_result_reader.sv - scoreboard bench over TURN=0,1,3 instances sharing control inputs
module tb_booth_result_reader;

    localparam int W = 8;
    localparam int TURNS [3] = '{0, 1, 3};

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  ibus [3];
    logic        ld_a [3];
    logic        ld_q [3];
    logic        busy [3];
    logic [15:0] prod [3];
    logic        prod_valid [3];
    logic        rd_done [3];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [15:0] exp_q [3][$];
    int  gap_cnt [3];
    int  rda_cyc [3];
    int  rd_cnt [3];
    int  done_cnt [3];
    bit  armed [3];
    bit  pv_d [3];
    bit  pend [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : inst
        booth_result_reader #(.W(W), .TURN(TURNS[g])) dut (
            .clk(clk),
            .rst_b(rst_b),
            .start(start),
            .ibus(ibus[g]),
            .ld_obus_a(ld_a[g]),
            .ld_obus_q(ld_q[g]),
            .busy(busy[g]),
            .prod(prod[g]),
            .prod_valid(prod_valid[g]),
            .out_ready(out_ready),
            .rd_done(rd_done[g])
        );
    end

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // bus model, enable checker and scoreboard; bus is driven only under an enable
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_b) begin
                exp_q[i].delete();
                armed[i] = 1'b0;
                pend[i]  = 1'b0;
                pv_d[i]  = 1'b0;
                ibus[i]  = 'x;
            end else begin
                check(32'(ld_a[i] & ld_q[i]), 0, "enable_overlap");
                check(32'(rd_done[i]), 32'(pend[i]), "rd_done");
                if (rd_done[i]) done_cnt[i]++;
                pend[i] = prod_valid[i] && out_ready;
                check(32'($isunknown(prod[i])), 0, "prod_has_x");
                if (ld_a[i]) begin
                    armed[i] = 1'b1;
                    gap_cnt[i] = 0;
                    rda_cyc[i] = cyc;
                    rd_cnt[i]++;
                end else if (ld_q[i] && armed[i]) begin
                    check(gap_cnt[i], TURNS[i], "gap_len");
                    armed[i] = 1'b0;
                end else if (armed[i]) begin
                    gap_cnt[i]++;
                end
                if (prod_valid[i] && !pv_d[i]) check(cyc - rda_cyc[i], TURNS[i] + 2, "latency");
                pv_d[i] = prod_valid[i];
                if (prod_valid[i] && out_ready) begin
                    check(32'(exp_q[i].size() > 0), 1, "sb_empty");
                    if (exp_q[i].size() > 0) check(prod[i], exp_q[i].pop_front(), "sb_prod");
                end
                if (ld_a[i] && exp_q[i].size() > 0)      ibus[i] = exp_q[i][0][15:8];
                else if (ld_q[i] && exp_q[i].size() > 0) ibus[i] = exp_q[i][0][7:0];
                else                                     ibus[i] = 'x;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] v);
        for (int i = 0; i < 3; i++) exp_q[i].push_back(v);
    endtask

    task automatic do_start(input logic [15:0] v);
        push_exp(v);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!(prod_valid[0] && prod_valid[1] && prod_valid[2]) && n < 50) begin
            step();
            n++;
        end
        check(32'(n < 50), 1, "valid_timeout");
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy[0] || busy[1] || busy[2]) && n < 50) begin
            step();
            n++;
        end
        check(32'(n < 50), 1, "idle_timeout");
        step();
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        int rc [3];
        int dc [3];
        for (int i = 0; i < 3; i++) begin
            rd_cnt[i] = 0;
            done_cnt[i] = 0;
        end
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            check(32'(busy[i]), 0, "rst_busy");
            check(32'(ld_a[i] | ld_q[i]), 0, "rst_enables");
            check(prod[i], 0, "rst_prod");
            check(32'(prod_valid[i] | rd_done[i]), 0, "rst_valid_done");
        end
        rst_b = 1'b1;
        step();

        // basic read with consumer always ready
        out_ready = 1'b1;
        do_start(16'hFE0C);
        wait_idle();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check(prod[i], 16'hFE0C, "basic_prod_hold");
            check(32'(prod_valid[i]), 0, "basic_valid_low");
            check(done_cnt[i], 1, "basic_done_cnt");
        end

        // backpressure: 5 stalled VALID cycles then accept
        for (int i = 0; i < 3; i++) dc[i] = done_cnt[i];
        do_start(16'h1234);
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 3; i++) begin
                check(32'(prod_valid[i]), 1, "bp_valid");
                check(prod[i], 16'h1234, "bp_prod");
            end
            step();
        end
        handshake();
        wait_idle();
        for (int i = 0; i < 3; i++) check(done_cnt[i] - dc[i], 1, "bp_single_done");

        // random reads with random consumer delay
        for (int r = 0; r < 100; r++) begin
            do_start(16'($urandom_range(0, 16'hFFFF)));
            wait_valid();
            repeat ($urandom_range(0, 3)) step();
            handshake();
            wait_idle();
        end

        // start held through RD_A and GAP must not queue a second read
        for (int i = 0; i < 3; i++) rc[i] = rd_cnt[i];
        do_start(16'h6699);
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        wait_valid();
        handshake();
        wait_idle();
        repeat (4) step();
        for (int i = 0; i < 3; i++) begin
            check(rd_cnt[i] - rc[i], 1, "ignored_start_reads");
            check(prod[i], 16'h6699, "ignored_start_prod");
        end

        // back-to-back: start with the completing handshake goes straight to RD_A
        do_start(16'h5AA5);
        wait_valid();
        push_exp(16'hA55A);
        start = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) check(32'(ld_a[i]), 1, "b2b_no_idle");
        wait_idle();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) check(prod[i], 16'hA55A, "b2b_prod");

        // asynchronous reset during GAP after A captured
        do_start(16'h7711);
        step();
        check(32'(ld_a[1] | ld_q[1]), 0, "gap_enables");
        check(32'(busy[1]), 1, "gap_busy");
        check(32'(prod[1][15:8]), 8'h77, "gap_a_captured");
        rst_b = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check(32'(ld_a[i] | ld_q[i]), 0, "arst_enables");
            check(32'(prod_valid[i] | busy[i]), 0, "arst_valid_busy");
            check(prod[i], 0, "arst_prod");
        end
        step();
        rst_b = 1'b1;
        step();
        out_ready = 1'b1;
        do_start(16'h3CC3);
        wait_idle();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) check(prod[i], 16'h3CC3, "post_reset_prod");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
